// File: rtl/adder_4bits_rr_scheduler_pkg.sv
// adder_4bits_rr_scheduler_pkg: shared widths, tag type and helpers for the adder scheduler
package adder_4bits_rr_scheduler_pkg;

    localparam int DATA_W  = 4;
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    // width of an index able to address n items, never less than one bit
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/adder_4bits_rr_scheduler_arb.sv
// adder_4bits_rr_scheduler_arb: round-robin arbiter whose pointer moves past each winner
module adder_4bits_rr_scheduler_arb #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [IDW-1:0] ptr;
    int             j;

    // first requester found scanning ptr, ptr+1, ... wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

    // pointer lands just after the last winner so it gets lowest priority next
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (any)
            ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/adder_4bits_rr_scheduler.sv
// adder_4bits_rr_scheduler: shares one 4-bit adder among NUM_REQ requesters with tagged responses
module adder_4bits_rr_scheduler
    import adder_4bits_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int IDW     = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         adder_a,
    output logic [DATA_W-1:0]         adder_b,
    output logic                      adder_vld,
    input  logic [DATA_W-1:0]         adder_sum,
    input  logic                      adder_c,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_c,
    output logic                      busy,
    output logic [CNT_W-1:0]          ops_done
);

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] clr;
    logic [IDW-1:0]     gidx;
    logic               gany;
    tag_t               pipe [PIPE_LAT+1];
    tag_t               tail;

    // a requester with an op in flight may not issue again; reset also blocks grants
    assign elig      = req_valid & ~pending & {NUM_REQ{en & ~rst}};
    assign req_ready = gnt;
    assign busy      = |pending;
    assign tail      = pipe[PIPE_LAT];

    adder_4bits_rr_scheduler_arb #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    // capture the winner's operands; hold them when nobody is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            adder_vld <= 1'b0;
            adder_a   <= '0;
            adder_b   <= '0;
        end else begin
            adder_vld <= gany;
            if (gany) begin
                adder_a <= req_a[DATA_W*gidx +: DATA_W];
                adder_b <= req_b[DATA_W*gidx +: DATA_W];
            end
        end
    end

    // tag shift pipe so the tail lines up with the adder output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= PIPE_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= tag_t'{vld: gany, id: MAX_IDW'(gidx)};
            for (int k = 1; k <= PIPE_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    // one-hot release of the requester whose result is being registered
    always_comb begin
        clr = '0;
        if (tail.vld) clr[tail.id[IDW-1:0]] = 1'b1;
    end

    // set on grant, clear as its response is loaded
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending | gnt) & ~clr;
    end

    // response registers fed by the tag tail and the adder result
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_c     <= 1'b0;
        end else begin
            rsp_valid <= tail.vld;
            if (tail.vld) begin
                rsp_id  <= tail.id[IDW-1:0];
                rsp_sum <= adder_sum;
                rsp_c   <= adder_c;
            end
        end
    end

    // saturating response counter
    always_ff @(posedge clk) begin
        if (rst)
            ops_done <= '0;
        else if (rsp_valid && !(&ops_done))
            ops_done <= ops_done + 1'b1;
    end

endmodule

// File: tb/tb_adder_4bits_rr_scheduler.sv
// tb_adder_4bits_rr_scheduler: directed checks of grant order, latency, drain and reset
module tb_adder_4bits_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [3:0]  req_valid = 4'hF;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [3:0]  adder_a;
    logic [3:0]  adder_b;
    logic        adder_vld;
    logic [3:0]  adder_sum;
    logic        adder_c;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_sum;
    logic        rsp_c;
    logic        busy;
    logic [15:0] ops_done;
    logic [4:0]  add_r;
    logic [3:0]  fs [4] = '{4'h0, 4'hD, 4'h9, 4'h0};
    logic        fc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          total = 0;
    int          bad = 0;

    adder_4bits_rr_scheduler #(
        .NUM_REQ  (4),
        .PIPE_LAT (1),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_vld (adder_vld),
        .adder_sum (adder_sum),
        .adder_c   (adder_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_c     (rsp_c),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    // shared adder with one cycle of latency
    always @(posedge clk) add_r <= {1'b0, adder_a} + {1'b0, adder_b};
    assign adder_sum = add_r[3:0];
    assign adder_c   = add_r[4];

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held with every requester asking
        repeat (3) tick();
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_adder_vld", 32'(adder_vld), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        req_valid = 4'h0;
        // single op 9+8 on requester 0
        tick();
        req_valid = 4'b0001;
        req_a = 16'h0009;
        req_b = 16'h0008;
        #2;
        chk("single_ready", 32'(req_ready), 1);
        tick();
        req_valid = 4'h0;
        #2;
        chk("single_adder_vld", 32'(adder_vld), 1);
        chk("single_adder_a", 32'(adder_a), 9);
        chk("single_adder_b", 32'(adder_b), 8);
        chk("single_busy", 32'(busy), 1);
        chk("single_ready_blocked", 32'(req_ready), 0);
        tick();
        #2;
        chk("single_rsp_early", 32'(rsp_valid), 0);
        chk("single_adder_idle", 32'(adder_vld), 0);
        tick();
        #2;
        chk("single_rsp_valid", 32'(rsp_valid), 1);
        chk("single_rsp_id", 32'(rsp_id), 0);
        chk("single_rsp_sum", 32'(rsp_sum), 1);
        chk("single_rsp_c", 32'(rsp_c), 1);
        chk("single_busy_low", 32'(busy), 0);
        tick();
        #2;
        chk("single_rsp_done", 32'(rsp_valid), 0);
        chk("single_ops_done", 32'(ops_done), 1);
        // requester 3 op F+1 moves the pointer back to 0
        tick();
        req_valid = 4'b1000;
        req_a = 16'hF000;
        req_b = 16'h1000;
        #2;
        chk("r3_ready", 32'(req_ready), 8);
        tick();
        req_valid = 4'h0;
        tick();
        tick();
        #2;
        chk("r3_rsp_valid", 32'(rsp_valid), 1);
        chk("r3_rsp_id", 32'(rsp_id), 3);
        chk("r3_rsp_sum", 32'(rsp_sum), 0);
        chk("r3_rsp_c", 32'(rsp_c), 1);
        // fairness with all four asking for 8 cycles
        req_a = 16'hC7A5;
        req_b = 16'h423B;
        for (int k = 0; k < 12; k++) begin
            tick();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #2;
            chk("fair_ready", 32'(req_ready), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
            if (k >= 3 && k <= 10) begin
                chk("fair_rsp_valid", 32'(rsp_valid), 1);
                chk("fair_rsp_id", 32'(rsp_id), 32'((k - 3) % 4));
                chk("fair_rsp_sum", 32'(rsp_sum), 32'(fs[(k - 3) % 4]));
                chk("fair_rsp_c", 32'(rsp_c), 32'(fc[(k - 3) % 4]));
            end else begin
                chk("fair_rsp_idle", 32'(rsp_valid), 0);
            end
        end
        chk("fair_ops_done", 32'(ops_done), 10);
        chk("fair_busy", 32'(busy), 0);
        // wrap: pointer at 3 with requesters 1 and 3 asking
        tick();
        req_valid = 4'b0100;
        #2;
        chk("wrap_pre", 32'(req_ready), 4);
        tick();
        req_valid = 4'b1010;
        #2;
        chk("wrap_g3", 32'(req_ready), 8);
        tick();
        #2;
        chk("wrap_g1", 32'(req_ready), 2);
        tick();
        req_valid = 4'h0;
        #2;
        chk("wrap_idle", 32'(req_ready), 0);
        chk("wrap_rsp2", 32'({rsp_valid, rsp_id}), 32'h6);
        tick();
        #2;
        chk("wrap_rsp3", 32'({rsp_valid, rsp_id}), 32'h7);
        tick();
        #2;
        chk("wrap_rsp1", 32'({rsp_valid, rsp_id}), 32'h5);
        tick();
        req_valid = 4'b1011;
        #2;
        chk("wrap_ptr2", 32'(req_ready), 8);
        tick();
        req_valid = 4'h0;
        tick();
        tick();
        #2;
        chk("wrap_rsp3b", 32'({rsp_valid, rsp_id}), 32'h7);
        tick();
        #2;
        chk("wrap_busy", 32'(busy), 0);
        chk("wrap_ops_done", 32'(ops_done), 14);
        // drain: three ops in flight, then en drops
        tick();
        req_valid = 4'hF;
        #2;
        chk("drain_g0", 32'(req_ready), 1);
        tick();
        #2;
        chk("drain_g1", 32'(req_ready), 2);
        tick();
        #2;
        chk("drain_g2", 32'(req_ready), 4);
        tick();
        en = 1'b0;
        #2;
        chk("drain_no_grant", 32'(req_ready), 0);
        chk("drain_busy", 32'(busy), 1);
        chk("drain_rsp0", 32'({rsp_valid, rsp_id}), 32'h4);
        tick();
        #2;
        chk("drain_no_grant2", 32'(req_ready), 0);
        chk("drain_rsp1", 32'({rsp_valid, rsp_id}), 32'h5);
        tick();
        #2;
        chk("drain_rsp2", 32'({rsp_valid, rsp_id}), 32'h6);
        chk("drain_busy_low", 32'(busy), 0);
        tick();
        #2;
        chk("drain_rsp_idle", 32'(rsp_valid), 0);
        chk("drain_busy_after", 32'(busy), 0);
        chk("drain_ready_off", 32'(req_ready), 0);
        chk("drain_ops_done", 32'(ops_done), 17);
        req_valid = 4'h0;
        en = 1'b1;
        // reset one cycle after two issues
        tick();
        req_valid = 4'b1001;
        #2;
        chk("mid_g3", 32'(req_ready), 8);
        tick();
        #2;
        chk("mid_g0", 32'(req_ready), 1);
        tick();
        rst = 1'b1;
        req_valid = 4'h0;
        #2;
        chk("mid_rst_ready", 32'(req_ready), 0);
        tick();
        rst = 1'b0;
        #2;
        chk("mid_rsp_gone", 32'(rsp_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_ops_done", 32'(ops_done), 0);
        chk("mid_adder_vld", 32'(adder_vld), 0);
        tick();
        #2;
        chk("mid_rsp_gone2", 32'(rsp_valid), 0);
        tick();
        req_valid = 4'b1001;
        #2;
        chk("mid_ptr0", 32'(req_ready), 1);
        chk("mid_rsp_gone3", 32'(rsp_valid), 0);
        tick();
        req_valid = 4'h0;
        #2;
        chk("post_adder_vld", 32'(adder_vld), 1);
        tick();
        tick();
        #2;
        chk("post_rsp", 32'({rsp_valid, rsp_id, rsp_sum, rsp_c}), 32'h81);
        tick();
        #2;
        chk("post_ops_done", 32'(ops_done), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
